timer_scheduler: RTL and testbench



---
 rtl/timer_scheduler_pkg.sv | 28 ++
 rtl/timer_scheduler_tick.sv | 27 ++
 rtl/timer_scheduler.sv | 114 +++++++++++
 tb/tb_timer_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_scheduler_pkg.sv
// Shared types and constants for the TIME1/TIME2 timer scheduler.
package timer_scheduler_pkg;

   typedef logic [3:0] reg_t;

   localparam reg_t REG_TIME1 = 4'd14;
   localparam reg_t REG_TIME2 = 4'd15;

   typedef enum logic {
      IDLE  = 1'b0,
      CARRY = 1'b1
   } timer_state_t;

   localparam logic [14:0] TIME_CNT_MASK = 15'h3FFF;
   localparam int          TIME_SIGN_BIT = 14;

   // 14-bit positive count increment; the sign bit is always written as 0.
   function automatic logic [14:0] time_inc(input logic [14:0] q);
      logic [14:0] s;
      s = (q & TIME_CNT_MASK) + 15'd1;
      return s & TIME_CNT_MASK;
   endfunction

   function automatic logic time_wraps(input logic [14:0] q);
      return (q & TIME_CNT_MASK) == TIME_CNT_MASK;
   endfunction

endpackage

// File: rtl/timer_scheduler_tick.sv
// Clock divider producing one tick per TICK_DIV enabled cycles; holds when disabled.
module tick_divider #(
   parameter int TICK_DIV = 1024
) (
   input  logic clk,
   input  logic rst_l,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/timer_scheduler.sv
// Schedules TIME1/TIME2 increments into register-file write port 2 behind the pipeline.
// Optional sticky dropped-tick flag: define TIMER_LOST_TICK_EN.
//
// state | meaning
// IDLE  | TIME1 increments issue whenever pend > 0 and port 2 is free
// CARRY | TIME1 wrapped; waiting for a free port to increment TIME2
module timer_scheduler
   import timer_scheduler_pkg::*;
#(
   parameter int TICK_DIV = 1024,
   parameter int PEND_MAX = 7
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        timer_en,
   input  logic        pipe_wr1_en,
   input  reg_t        pipe_wr1_sel,
   input  logic        pipe_wr2_en,
   input  reg_t        pipe_wr2_sel,
   input  logic [14:0] pipe_wr2_data,
   input  logic [14:0] time1_q,
   input  logic [14:0] time2_q,
   output logic        rf_wr2_en,
   output reg_t        rf_wr2_sel,
   output logic [14:0] rf_wr2_data,
   output logic        stall_req,
   output logic        t2_ovf,
   output logic        lost_tick
);

   localparam int              PW        = $clog2(PEND_MAX + 1);
   localparam logic [PW-1:0]   PEND_FULL = PW'(PEND_MAX);

   timer_state_t  state, state_nxt;
   logic [PW-1:0] pend;
   logic          tick;
   logic          issue_t1, issue_t2;
   logic          t1_busy, t2_busy;

   tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
      .clk   (clk),
      .rst_l (rst_l),
      .en    (timer_en),
      .tick  (tick)
   );

   // Port 2 being busy already covers a pipeline port-2 write to either timer.
   assign t1_busy  = pipe_wr1_en && (pipe_wr1_sel == REG_TIME1);
   assign t2_busy  = pipe_wr1_en && (pipe_wr1_sel == REG_TIME2);
   assign issue_t1 = (state == IDLE)  && (pend != '0) && !pipe_wr2_en && !t1_busy;
   assign issue_t2 = (state == CARRY) && !pipe_wr2_en && !t2_busy;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue_t1 && time_wraps(time1_q)) state_nxt = CARRY;
         CARRY:   if (issue_t2) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rf_wr2_en   = pipe_wr2_en;
      rf_wr2_sel  = pipe_wr2_sel;
      rf_wr2_data = pipe_wr2_data;
      t2_ovf      = 1'b0;
      if (issue_t1) begin
         rf_wr2_en   = 1'b1;
         rf_wr2_sel  = REG_TIME1;
         rf_wr2_data = time_inc(time1_q);
      end else if (issue_t2) begin
         rf_wr2_en   = 1'b1;
         rf_wr2_sel  = REG_TIME2;
         rf_wr2_data = time_inc(time2_q);
         t2_ovf      = time_wraps(time2_q);
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         pend <= '0;
      end else if (tick && !issue_t1) begin
         if (pend != PEND_FULL) pend <= pend + PW'(1);
      end else if (issue_t1 && !tick) begin
         pend <= pend - PW'(1);
      end
   end

   // Registered-only decode so the pipeline sees no combinational path from its own outputs.
   assign stall_req = (pend == PEND_FULL) || (state == CARRY);

`ifdef TIMER_LOST_TICK_EN
   logic lost_q;
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         lost_q <= 1'b0;
      end else if (tick && !issue_t1 && (pend == PEND_FULL)) begin
         lost_q <= 1'b1;
      end
   end
   assign lost_tick = lost_q;
`else
   assign lost_tick = 1'b0;
`endif

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed self-checking bench for timer_scheduler (TICK_DIV=4, PEND_MAX=7).
module tb_timer_scheduler;
   import timer_scheduler_pkg::*;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        timer_en = 1'b0;
   logic        pipe_wr1_en = 1'b0;
   reg_t        pipe_wr1_sel = '0;
   logic        pipe_wr2_en = 1'b0;
   reg_t        pipe_wr2_sel = '0;
   logic [14:0] pipe_wr2_data = '0;
   logic [14:0] time1_q = '0;
   logic [14:0] time2_q = '0;
   logic        rf_wr2_en;
   reg_t        rf_wr2_sel;
   logic [14:0] rf_wr2_data;
   logic        stall_req;
   logic        t2_ovf;
   logic        lost_tick;

   int checks = 0;
   int failures = 0;

`ifdef TIMER_LOST_TICK_EN
   localparam logic LOST_EXP = 1'b1;
`else
   localparam logic LOST_EXP = 1'b0;
`endif

   timer_scheduler #(.TICK_DIV(4), .PEND_MAX(7)) dut (
      .clk           (clk),
      .rst_l         (rst_l),
      .timer_en      (timer_en),
      .pipe_wr1_en   (pipe_wr1_en),
      .pipe_wr1_sel  (pipe_wr1_sel),
      .pipe_wr2_en   (pipe_wr2_en),
      .pipe_wr2_sel  (pipe_wr2_sel),
      .pipe_wr2_data (pipe_wr2_data),
      .time1_q       (time1_q),
      .time2_q       (time2_q),
      .rf_wr2_en     (rf_wr2_en),
      .rf_wr2_sel    (rf_wr2_sel),
      .rf_wr2_data   (rf_wr2_data),
      .stall_req     (stall_req),
      .t2_ovf        (t2_ovf),
      .lost_tick     (lost_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // reset: outputs idle, port 2 passes straight through
      #3;
      pipe_wr2_en = 1'b1; pipe_wr2_sel = 4'd3; pipe_wr2_data = 15'h123;
      #1;
      chk("rst_stall", stall_req, 0);
      chk("rst_t2_ovf", t2_ovf, 0);
      chk("rst_lost", lost_tick, 0);
      chk("rst_pass_en", rf_wr2_en, 1);
      chk("rst_pass_sel", rf_wr2_sel, 4'd3);
      chk("rst_pass_data", rf_wr2_data, 15'h123);

      // first tick after 4 edges, issue visible the following cycle
      step();
      pipe_wr2_en = 1'b0; rst_l = 1'b1; timer_en = 1'b1;
      #1;
      chk("idle_en", rf_wr2_en, 0);
      repeat (3) step();
      #1;
      chk("pre_tick_en", rf_wr2_en, 0);
      step();
      timer_en = 1'b0;
      #1;
      chk("first_issue_en", rf_wr2_en, 1);
      chk("first_issue_sel", rf_wr2_sel, REG_TIME1);
      chk("first_issue_data", rf_wr2_data, 15'd1);
      step();
      time1_q = 15'd1;
      #1;
      chk("after_issue_en", rf_wr2_en, 0);

      // pipeline holds port 2 for 40 cycles; pend saturates at edge 28
      timer_en = 1'b1; pipe_wr2_en = 1'b1; pipe_wr2_sel = 4'd5;
      for (int k = 1; k <= 40; k++) begin
         step();
         pipe_wr2_data = 15'(k * 3);
         #1;
         chk("sat_mirror_en", rf_wr2_en, 1);
         chk("sat_mirror_sel", rf_wr2_sel, 4'd5);
         chk("sat_mirror_data", rf_wr2_data, 15'(k * 3));
         chk("sat_stall", stall_req, (k >= 28) ? 1 : 0);
      end
      pipe_wr2_en = 1'b0; timer_en = 1'b0;
      chk("sat_lost", lost_tick, LOST_EXP);
      for (int i = 0; i < 7; i++) begin
         time1_q = 15'(1 + i);
         #1;
         chk("drain_en", rf_wr2_en, 1);
         chk("drain_sel", rf_wr2_sel, REG_TIME1);
         chk("drain_data", rf_wr2_data, 15'(2 + i));
         chk("drain_stall", stall_req, (i == 0) ? 1 : 0);
         step();
      end
      time1_q = 15'd8;
      #1;
      chk("drained_en", rf_wr2_en, 0);
      chk("drained_stall", stall_req, 0);

      // TIME1 wrap, carry deferred one cycle by the pipeline, TIME2 5 -> 6
      time1_q = 15'h3FFF; time2_q = 15'd5; timer_en = 1'b1;
      repeat (4) step();
      timer_en = 1'b0;
      #1;
      chk("wrap_t1_en", rf_wr2_en, 1);
      chk("wrap_t1_sel", rf_wr2_sel, REG_TIME1);
      chk("wrap_t1_data", rf_wr2_data, 15'd0);
      chk("wrap_t1_stall", stall_req, 0);
      step();
      time1_q = 15'd0; pipe_wr2_en = 1'b1; pipe_wr2_sel = 4'd2; pipe_wr2_data = 15'd77;
      #1;
      chk("carry_stall", stall_req, 1);
      chk("carry_pipe_sel", rf_wr2_sel, 4'd2);
      chk("carry_pipe_data", rf_wr2_data, 15'd77);
      chk("carry_pipe_ovf", t2_ovf, 0);
      step();
      pipe_wr2_en = 1'b0;
      #1;
      chk("carry_t2_en", rf_wr2_en, 1);
      chk("carry_t2_sel", rf_wr2_sel, REG_TIME2);
      chk("carry_t2_data", rf_wr2_data, 15'd6);
      chk("carry_t2_ovf", t2_ovf, 0);
      step();
      time2_q = 15'd6;
      #1;
      chk("carry_done_en", rf_wr2_en, 0);
      chk("carry_done_stall", stall_req, 0);

      // both timers wrap: t2_ovf for exactly one cycle
      time1_q = 15'h3FFF; time2_q = 15'h3FFF; timer_en = 1'b1;
      repeat (4) step();
      timer_en = 1'b0;
      #1;
      chk("ovf_t1_data", rf_wr2_data, 15'd0);
      chk("ovf_t1_ovf", t2_ovf, 0);
      step();
      time1_q = 15'd0;
      #1;
      chk("ovf_t2_sel", rf_wr2_sel, REG_TIME2);
      chk("ovf_t2_data", rf_wr2_data, 15'd0);
      chk("ovf_pulse", t2_ovf, 1);
      step();
      time2_q = 15'd0;
      #1;
      chk("ovf_pulse_end", t2_ovf, 0);
      chk("ovf_end_en", rf_wr2_en, 0);

      // port-1 write to TIME1 defers the increment onto the new value
      time1_q = 15'd10; timer_en = 1'b1;
      repeat (4) step();
      timer_en = 1'b0; pipe_wr1_en = 1'b1; pipe_wr1_sel = REG_TIME1;
      #1;
      chk("defer_en", rf_wr2_en, 0);
      step();
      pipe_wr1_en = 1'b0; time1_q = 15'd100;
      #1;
      chk("defer_issue_en", rf_wr2_en, 1);
      chk("defer_issue_sel", rf_wr2_sel, REG_TIME1);
      chk("defer_issue_data", rf_wr2_data, 15'd101);
      step();
      time1_q = 15'd101;
      #1;
      chk("defer_done_en", rf_wr2_en, 0);

      // reset while in CARRY with a tick still pending
      time1_q = 15'h3FFF; time2_q = 15'd20; timer_en = 1'b1;
      pipe_wr2_en = 1'b1; pipe_wr2_sel = 4'd3;
      repeat (8) step();
      timer_en = 1'b0; pipe_wr2_en = 1'b0;
      #1;
      chk("rc_t1_en", rf_wr2_en, 1);
      chk("rc_t1_data", rf_wr2_data, 15'd0);
      step();
      time1_q = 15'd0;
      #1;
      chk("rc_carry_stall", stall_req, 1);
      rst_l = 1'b0;
      #1;
      chk("rc_rst_stall", stall_req, 0);
      chk("rc_rst_en", rf_wr2_en, 0);
      chk("rc_rst_ovf", t2_ovf, 0);
      chk("rc_rst_lost", lost_tick, 0);
      step();
      rst_l = 1'b1;
      #1;
      chk("rc_rel_en", rf_wr2_en, 0);
      for (int j = 0; j < 3; j++) begin
         step();
         #1;
         chk("rc_no_write", rf_wr2_en, 0);
         chk("rc_no_stall", stall_req, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
